// File: rtl/period_gen_if.sv
// period_gen_if: configuration handshake bundle offered to period_gen
interface period_gen_if #(
   parameter int P_W = 16,
   parameter int N_W = 8
);
   logic           cfg_valid;
   logic           cfg_ready;
   logic [P_W-1:0] cfg_period;
   logic [P_W-1:0] cfg_high;
   logic [N_W-1:0] cfg_count;
   modport master (output cfg_valid, cfg_period, cfg_high, cfg_count, input cfg_ready);
   modport slave  (input cfg_valid, cfg_period, cfg_high, cfg_count, output cfg_ready);
endinterface

// File: rtl/period_gen.sv
// period_gen: programmable pulse generator with bursts and boundary-aligned reconfig; PERIOD_GEN_STROBE_EN adds period_stb
module period_gen #(
   parameter int P_W = 16,
   parameter int N_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   period_gen_if.slave    cfg,
   input  logic           start,
   input  logic           stop,
   output logic           test_out,
   output logic           busy,
   output logic           done,
   output logic [N_W-1:0] pulse_cnt
`ifdef PERIOD_GEN_STROBE_EN
   ,
   output logic           period_stb
`endif
);
   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
   state_t         state_q, state_d;
   logic [P_W-1:0] ph_q, ph_d, act_p_q, act_p_d, act_h_q, act_h_d;
   logic [P_W-1:0] pend_p_q, pend_p_d, pend_h_q, pend_h_d, clamp_p, clamp_h;
   logic [N_W-1:0] cnt_q, cnt_d, act_n_q, act_n_d, pend_n_q, pend_n_d, cnt_inc;
   logic           pend_full_q, pend_full_d, out_q, out_d, done_q, done_d;
   logic           acc, running, bnd, fin, ending, launch;
`ifdef PERIOD_GEN_STROBE_EN
   logic           stb_q, stb_d;
`endif
   assign cfg.cfg_ready = ~pend_full_q;
   assign test_out      = out_q;
   assign busy          = (state_q != IDLE);
   assign done          = done_q;
   assign pulse_cnt     = cnt_q;
`ifdef PERIOD_GEN_STROBE_EN
   assign period_stb    = stb_q;
`endif
   // clamp offered config, advance phase and counters, stage config at boundaries, precompute registered outputs
   always_comb begin
      acc         = cfg.cfg_valid && cfg.cfg_ready;
      clamp_p     = (cfg.cfg_period < P_W'(2)) ? P_W'(2) : cfg.cfg_period;
      clamp_h     = (cfg.cfg_high == '0) ? P_W'(1) : (cfg.cfg_high >= clamp_p) ? clamp_p - P_W'(1) : cfg.cfg_high;
      running     = (state_q != IDLE);
      launch      = !running && start && !stop;
      bnd         = running && (ph_q == act_p_q - P_W'(1));
      cnt_inc     = cnt_q + N_W'(1);
      fin         = (act_n_q != '0) && (cnt_inc == act_n_q);
      ending      = bnd && (fin || stop || state_q == STOPPING);
      ph_d        = (running && !bnd) ? ph_q + P_W'(1) : '0;
      cnt_d       = launch ? '0 : bnd ? cnt_inc : cnt_q;
      state_d     = launch ? RUN : ending ? IDLE : (state_q == RUN && stop) ? STOPPING : state_q;
      act_p_d     = act_p_q;
      act_h_d     = act_h_q;
      act_n_d     = act_n_q;
      pend_p_d    = pend_p_q;
      pend_h_d    = pend_h_q;
      pend_n_d    = pend_n_q;
      pend_full_d = pend_full_q;
      if (pend_full_q && (bnd || !running)) begin
         act_p_d     = pend_p_q;
         act_h_d     = pend_h_q;
         act_n_d     = pend_n_q;
         pend_full_d = 1'b0;
      end
      if (acc && !running) begin
         act_p_d = clamp_p;
         act_h_d = clamp_h;
         act_n_d = cfg.cfg_count;
      end
      if (acc && running) begin
         pend_p_d    = clamp_p;
         pend_h_d    = clamp_h;
         pend_n_d    = cfg.cfg_count;
         pend_full_d = 1'b1;
      end
      out_d  = (state_d != IDLE) && (ph_d < act_h_d);
      done_d = (state_d != IDLE) && (ph_d == act_p_d - P_W'(1)) && (act_n_d != '0) && (N_W'(cnt_d + N_W'(1)) == act_n_d);
`ifdef PERIOD_GEN_STROBE_EN
      stb_d  = out_d && !out_q;
`endif
   end
   // state, phase, config slots and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ph_q        <= '0;
         cnt_q       <= '0;
         act_p_q     <= P_W'(2);
         act_h_q     <= P_W'(1);
         act_n_q     <= '0;
         pend_p_q    <= '0;
         pend_h_q    <= '0;
         pend_n_q    <= '0;
         pend_full_q <= 1'b0;
         out_q       <= 1'b0;
         done_q      <= 1'b0;
`ifdef PERIOD_GEN_STROBE_EN
         stb_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ph_q        <= ph_d;
         cnt_q       <= cnt_d;
         act_p_q     <= act_p_d;
         act_h_q     <= act_h_d;
         act_n_q     <= act_n_d;
         pend_p_q    <= pend_p_d;
         pend_h_q    <= pend_h_d;
         pend_n_q    <= pend_n_d;
         pend_full_q <= pend_full_d;
         out_q       <= out_d;
         done_q      <= done_d;
`ifdef PERIOD_GEN_STROBE_EN
         stb_q       <= stb_d;
`endif
      end
   end
endmodule

// File: tb/tb_period_gen.sv
// tb_period_gen: scoreboard bench for period_gen, expected waveform queued per scenario and popped per cycle
module tb_period_gen;
   localparam int P_W = 16;
   localparam int N_W = 8;
   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           stop = 1'b0;
   logic           test_out, busy, done;
   logic [N_W-1:0] pulse_cnt;
`ifdef PERIOD_GEN_STROBE_EN
   logic           period_stb;
`endif
   int             total = 0;
   int             bad = 0;
   bit             exp_q[$];

   period_gen_if #(.P_W(P_W), .N_W(N_W)) cif ();

   period_gen #(.P_W(P_W), .N_W(N_W)) dut (
      .clk(clk),
      .rst(rst),
      .cfg(cif),
      .start(start),
      .stop(stop),
      .test_out(test_out),
      .busy(busy),
      .done(done),
      .pulse_cnt(pulse_cnt)
`ifdef PERIOD_GEN_STROBE_EN
      ,
      .period_stb(period_stb)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wave(input int p, input int h, input int n);
      for (int k = 0; k < n; k++)
         for (int j = 0; j < p; j++)
            exp_q.push_back(j < h);
   endtask

   task automatic load_cfg(input int p, input int h, input int n);
      cif.cfg_valid  = 1'b1;
      cif.cfg_period = P_W'(p);
      cif.cfg_high   = P_W'(h);
      cif.cfg_count  = N_W'(n);
      step();
      cif.cfg_valid  = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 64) begin
         step();
         n++;
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL %s_idle busy=%b required=0 after %0d cycles", tag, busy, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total += 5;
      if (test_out !== 1'b0) begin bad++; $display("FAIL rst_out got=%b exp=0", test_out); end
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
      if (pulse_cnt !== '0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", pulse_cnt); end
      if (cif.cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", cif.cfg_ready); end
      rst = 1'b0;
      step();
      total += 2;
      if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b exp=0", busy); end
      if (cif.cfg_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b exp=1", cif.cfg_ready); end
   endtask

   task automatic test_burst();
      bit e;
      load_cfg(10, 3, 4);
      push_wave(10, 3, 4);
      go();
      for (int i = 0; i < 40; i++) begin
         e = exp_q.pop_front();
         total += 4;
         if (test_out !== e) begin bad++; $display("FAIL burst_out cyc=%0d got=%b exp=%b", i, test_out, e); end
         if (busy !== 1'b1) begin bad++; $display("FAIL burst_busy cyc=%0d got=%b exp=1", i, busy); end
         if (done !== (i == 39)) begin bad++; $display("FAIL burst_done cyc=%0d got=%b exp=%b", i, done, i == 39); end
         if (pulse_cnt !== N_W'(i / 10)) begin bad++; $display("FAIL burst_cnt cyc=%0d got=%0d exp=%0d", i, pulse_cnt, i / 10); end
`ifdef PERIOD_GEN_STROBE_EN
         total++;
         if (period_stb !== (i % 10 == 0)) begin bad++; $display("FAIL burst_stb cyc=%0d got=%b exp=%b", i, period_stb, i % 10 == 0); end
`endif
         step();
      end
      total += 4;
      if (test_out !== 1'b0) begin bad++; $display("FAIL burst_end_out got=%b exp=0", test_out); end
      if (busy !== 1'b0) begin bad++; $display("FAIL burst_end_busy got=%b exp=0", busy); end
      if (done !== 1'b0) begin bad++; $display("FAIL burst_end_done got=%b exp=0", done); end
      if (pulse_cnt !== N_W'(4)) begin bad++; $display("FAIL burst_end_cnt got=%0d exp=4", pulse_cnt); end
   endtask

   task automatic test_clamp();
      bit e;
      load_cfg(1, 5, 0);
      push_wave(2, 1, 6);
      go();
      for (int i = 0; i < 12; i++) begin
         e = exp_q.pop_front();
         total += 2;
         if (test_out !== e) begin bad++; $display("FAIL clamp_out cyc=%0d got=%b exp=%b", i, test_out, e); end
         if (busy !== 1'b1) begin bad++; $display("FAIL clamp_busy cyc=%0d got=%b exp=1", i, busy); end
         step();
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      wait_idle("clamp");
      load_cfg(6, 0, 1);
      push_wave(6, 1, 1);
      go();
      for (int i = 0; i < 6; i++) begin
         e = exp_q.pop_front();
         total += 2;
         if (test_out !== e) begin bad++; $display("FAIL clamph_out cyc=%0d got=%b exp=%b", i, test_out, e); end
         if (done !== (i == 5)) begin bad++; $display("FAIL clamph_done cyc=%0d got=%b exp=%b", i, done, i == 5); end
         step();
      end
      total += 2;
      if (busy !== 1'b0) begin bad++; $display("FAIL clamph_end_busy got=%b exp=0", busy); end
      if (pulse_cnt !== N_W'(1)) begin bad++; $display("FAIL clamph_end_cnt got=%0d exp=1", pulse_cnt); end
   endtask

   task automatic test_reconfig();
      bit e;
      logic er;
      load_cfg(8, 4, 0);
      push_wave(8, 4, 1);
      push_wave(4, 2, 3);
      cif.cfg_period = P_W'(4);
      cif.cfg_high   = P_W'(2);
      cif.cfg_count  = '0;
      go();
      for (int i = 0; i < 20; i++) begin
         e  = exp_q.pop_front();
         er = !(i >= 4 && i <= 7);
         total += 2;
         if (test_out !== e) begin bad++; $display("FAIL reconf_out cyc=%0d got=%b exp=%b", i, test_out, e); end
         if (cif.cfg_ready !== er) begin bad++; $display("FAIL reconf_ready cyc=%0d got=%b exp=%b", i, cif.cfg_ready, er); end
         cif.cfg_valid = (i == 3);
         step();
      end
      cif.cfg_valid = 1'b0;
      stop = 1'b1;
      step();
      stop = 1'b0;
      wait_idle("reconf");
   endtask

   task automatic test_stop();
      bit e;
      load_cfg(10, 3, 0);
      push_wave(10, 3, 1);
      go();
      for (int i = 0; i < 10; i++) begin
         e = exp_q.pop_front();
         total += 3;
         if (test_out !== e) begin bad++; $display("FAIL stop_out cyc=%0d got=%b exp=%b", i, test_out, e); end
         if (busy !== 1'b1) begin bad++; $display("FAIL stop_busy cyc=%0d got=%b exp=1", i, busy); end
         if (done !== 1'b0) begin bad++; $display("FAIL stop_done cyc=%0d got=%b exp=0", i, done); end
         stop = (i == 2);
         step();
      end
      stop = 1'b0;
      total += 4;
      if (test_out !== 1'b0) begin bad++; $display("FAIL stop_end_out got=%b exp=0", test_out); end
      if (busy !== 1'b0) begin bad++; $display("FAIL stop_end_busy got=%b exp=0", busy); end
      if (done !== 1'b0) begin bad++; $display("FAIL stop_end_done got=%b exp=0", done); end
      if (pulse_cnt !== N_W'(1)) begin bad++; $display("FAIL stop_end_cnt got=%0d exp=1", pulse_cnt); end
   endtask

   task automatic test_stop_final();
      bit e;
      load_cfg(4, 2, 3);
      push_wave(4, 2, 3);
      go();
      for (int i = 0; i < 12; i++) begin
         e = exp_q.pop_front();
         total += 2;
         if (test_out !== e) begin bad++; $display("FAIL fin_out cyc=%0d got=%b exp=%b", i, test_out, e); end
         if (done !== (i == 11)) begin bad++; $display("FAIL fin_done cyc=%0d got=%b exp=%b", i, done, i == 11); end
         stop = (i == 11);
         step();
      end
      stop = 1'b0;
      total += 4;
      if (done !== 1'b0) begin bad++; $display("FAIL fin_end_done got=%b exp=0", done); end
      if (busy !== 1'b0) begin bad++; $display("FAIL fin_end_busy got=%b exp=0", busy); end
      if (test_out !== 1'b0) begin bad++; $display("FAIL fin_end_out got=%b exp=0", test_out); end
      if (pulse_cnt !== N_W'(3)) begin bad++; $display("FAIL fin_end_cnt got=%0d exp=3", pulse_cnt); end
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      total += 3;
      if (busy !== 1'b0) begin bad++; $display("FAIL ss_busy got=%b exp=0", busy); end
      if (test_out !== 1'b0) begin bad++; $display("FAIL ss_out got=%b exp=0", test_out); end
      if (pulse_cnt !== N_W'(3)) begin bad++; $display("FAIL ss_cnt got=%0d exp=3", pulse_cnt); end
      step();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL ss_busy2 got=%b exp=0", busy); end
   endtask

   task automatic test_reset_midrun();
      bit e;
      load_cfg(8, 4, 0);
      go();
      for (int i = 0; i < 10; i++) step();
      load_cfg(20, 10, 0);
      total++;
      if (cif.cfg_ready !== 1'b0) begin bad++; $display("FAIL mid_pend_ready got=%b exp=0", cif.cfg_ready); end
      rst = 1'b1;
      step();
      total += 5;
      if (test_out !== 1'b0) begin bad++; $display("FAIL mid_rst_out got=%b exp=0", test_out); end
      if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
      if (done !== 1'b0) begin bad++; $display("FAIL mid_rst_done got=%b exp=0", done); end
      if (pulse_cnt !== '0) begin bad++; $display("FAIL mid_rst_cnt got=%0d exp=0", pulse_cnt); end
      if (cif.cfg_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b exp=1", cif.cfg_ready); end
      rst = 1'b0;
      push_wave(2, 1, 3);
      go();
      for (int i = 0; i < 6; i++) begin
         e = exp_q.pop_front();
         total++;
         if (test_out !== e) begin bad++; $display("FAIL mid_dflt_out cyc=%0d got=%b exp=%b", i, test_out, e); end
         step();
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      wait_idle("mid");
   endtask

   initial begin
      cif.cfg_valid  = 1'b0;
      cif.cfg_period = '0;
      cif.cfg_high   = '0;
      cif.cfg_count  = '0;
      test_reset();
      test_burst();
      test_clamp();
      test_reconfig();
      test_stop();
      test_stop_final();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
